// File: rtl/isa_instr_sequencer.sv
// Clocked instruction source for the ISA datapath: fetches program words, holds them on
// instr_out for SETTLE cycles, then emits Salida on a valid/ready stream. Optional macro: ISA_SEQ_HALT_EN.
module isa_instr_sequencer #(
  parameter int    MEM_DEPTH = 256,
  parameter int    PROG_LEN  = 30,
  parameter int    SETTLE    = 2,
  parameter string MEM_FILE  = "datos_convertidos.txt",
  localparam int   AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [19:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   len_in,
  output logic [19:0]   instr_out,
  input  logic [31:0]   salida_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [AW-1:0] res_addr,
  output logic          busy,
  output logic          done,
`ifdef ISA_SEQ_HALT_EN
  output logic          halted,
`endif
  output logic [AW-1:0] pc
);

  // Result stream: a result transfers on the rising edge where res_valid && res_ready;
  // res_data/res_addr are stable while res_valid is high and not yet accepted.

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SETTLE, ST_CAPTURE, ST_HOLD, ST_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_W     = (AW+1)'(MEM_DEPTH);
  localparam logic [AW:0] DEF_LEN     = (PROG_LEN > MEM_DEPTH) ? DEPTH_W : (AW+1)'(PROG_LEN);
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE - 1);

  logic [19:0]   r_mem [MEM_DEPTH];
  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_cnt;
  logic [3:0]    r_settle;
  logic [19:0]   r_instr;
  logic          r_res_valid;
  logic [31:0]   r_res_data;
  logic [AW-1:0] r_res_addr;
  logic          r_busy;
  logic          r_done;
  logic [AW:0]   w_len_sel;
  logic [AW:0]   w_len_sat;
  logic          w_last;
  logic          w_xfer;
  logic          w_halt;

  // Program writes are unconditional; a fetch of the same address sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  assign w_len_sel = (len_in == '0) ? DEF_LEN : len_in;
  assign w_len_sat = (w_len_sel > DEPTH_W) ? DEPTH_W : w_len_sel;
  assign w_last    = ({1'b0, r_pc} == (r_cnt - 1'b1));
  assign w_xfer    = r_res_valid && res_ready;

`ifdef ISA_SEQ_HALT_EN
  assign w_halt = (r_mem[r_pc] == 20'h00000);
`else
  assign w_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_FETCH;
      ST_FETCH:   w_next = w_halt ? ST_DONE : ST_SETTLE;
      ST_SETTLE:  if (r_settle == '0) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_HOLD;
      ST_HOLD:    if (w_xfer) w_next = w_last ? ST_DONE : ST_FETCH;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_cnt       <= '0;
      r_settle    <= '0;
      r_instr     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt  <= w_len_sat;
            r_pc   <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_instr  <= r_mem[r_pc];
          r_settle <= SETTLE_INIT;
          if (w_halt) r_busy <= 1'b0;
        end
        ST_SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - 1'b1;
        end
        ST_CAPTURE: begin
          r_res_data  <= salida_in;
          r_res_addr  <= r_pc;
          r_res_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (w_xfer) begin
            r_res_valid <= 1'b0;
            if (w_last) r_busy <= 1'b0;
            else        r_pc   <= r_pc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ISA_SEQ_HALT_EN
  logic r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_halted <= 1'b0;
    else if (r_state == ST_IDLE && start)     r_halted <= 1'b0;
    else if (r_state == ST_FETCH && w_halt)   r_halted <= 1'b1;
  end

  assign halted = r_halted;
`endif

  assign pc        = r_pc;
  assign instr_out = r_instr;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_addr  = r_res_addr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
